// File: rtl/uart_tx_frame.sv
// Pixel-to-UART frame transmitter: splits RGB pixels into bytes, queues them, sends 8N1.
// Optional UART_TX_FRAME_HEADER_EN prefixes each frame with the bytes 0xAA, 0x55.
module uart_tx_frame #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 5,
  parameter int CLK_FREQ        = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int IMG_WIDTH       = 80,
  parameter int IMG_HEIGHT      = 120,
  parameter int TOTAL_PIXELS    = IMG_WIDTH * IMG_HEIGHT,
  parameter int PIXEL_CNT_WIDTH = $clog2(TOTAL_PIXELS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pixel_valid,
  input  logic [3*DATA_WIDTH-1:0]    rgb_data,
  output logic                       pixel_ready,
  output logic                       tx,
  output logic                       tx_busy,
  output logic [PIXEL_CNT_WIDTH-1:0] pixel_cnt,
  output logic                       frame_done
);

  localparam int DEPTH    = 2 ** FIFO_DEPTH;
  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W   = $clog2(BIT_CLKS + 1);
  localparam int BIT_W    = $clog2(DATA_WIDTH);

`ifdef UART_TX_FRAME_HEADER_EN
  typedef enum logic [2:0] {DIS_IDLE, DIS_HDR0, DIS_HDR1, DIS_BYTE_R, DIS_BYTE_G, DIS_BYTE_B} dis_state_t;
`else
  typedef enum logic [1:0] {DIS_IDLE, DIS_BYTE_R, DIS_BYTE_G, DIS_BYTE_B} dis_state_t;
`endif
  typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_t;

  dis_state_t                 dis_state_reg;
  ser_state_t                 ser_state_reg;
  logic [3*DATA_WIDTH-1:0]    pix_reg;
  logic [PIXEL_CNT_WIDTH-1:0] pixel_cnt_reg;
  logic                       frame_pend_reg;
  logic                       pixel_ready_reg;
  logic                       frame_done_reg;
  logic                       tx_reg;
  logic [BAUD_W-1:0]          baud_cnt_reg;
  logic [BIT_W-1:0]           bit_cnt_reg;
  logic [DATA_WIDTH-1:0]      shift_reg;

  logic [DATA_WIDTH-1:0]      fifo_mem [DEPTH];
  logic [FIFO_DEPTH:0]        wr_ptr_reg;
  logic [FIFO_DEPTH:0]        rd_ptr_reg;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       push;
  logic                       pop;
  logic [DATA_WIDTH-1:0]      push_data;
  logic                       baud_end;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[FIFO_DEPTH] != rd_ptr_reg[FIFO_DEPTH]) &&
                      (wr_ptr_reg[FIFO_DEPTH-1:0] == rd_ptr_reg[FIFO_DEPTH-1:0]);
  assign baud_end   = (baud_cnt_reg == BAUD_W'(BIT_CLKS - 1));
  // Popping at the end of STOP lets the next start bit follow with no idle gap.
  assign pop        = !fifo_empty &&
                      ((ser_state_reg == SER_IDLE) || (ser_state_reg == SER_STOP && baud_end));

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    case (dis_state_reg)
`ifdef UART_TX_FRAME_HEADER_EN
      DIS_HDR0:   begin push = !fifo_full; push_data = DATA_WIDTH'(8'hAA); end
      DIS_HDR1:   begin push = !fifo_full; push_data = DATA_WIDTH'(8'h55); end
`endif
      DIS_BYTE_R: begin push = !fifo_full; push_data = pix_reg[3*DATA_WIDTH-1:2*DATA_WIDTH]; end
      DIS_BYTE_G: begin push = !fifo_full; push_data = pix_reg[2*DATA_WIDTH-1:DATA_WIDTH]; end
      DIS_BYTE_B: begin push = !fifo_full; push_data = pix_reg[DATA_WIDTH-1:0]; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[FIFO_DEPTH-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Disassembly FSM, pixel counter and frame completion bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dis_state_reg   <= DIS_IDLE;
      pix_reg         <= '0;
      pixel_cnt_reg   <= '0;
      frame_pend_reg  <= 1'b0;
      pixel_ready_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (dis_state_reg)
        DIS_IDLE: begin
          if (pixel_valid && pixel_ready_reg) begin
            pix_reg         <= rgb_data;
            pixel_ready_reg <= 1'b0;
`ifdef UART_TX_FRAME_HEADER_EN
            dis_state_reg   <= (pixel_cnt_reg == '0) ? DIS_HDR0 : DIS_BYTE_R;
`else
            dis_state_reg   <= DIS_BYTE_R;
`endif
            if (pixel_cnt_reg == PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1)) begin
              pixel_cnt_reg  <= '0;
              frame_pend_reg <= 1'b1;
            end else begin
              pixel_cnt_reg  <= pixel_cnt_reg + 1'b1;
            end
          end else if (frame_pend_reg && fifo_empty && ser_state_reg == SER_IDLE) begin
            frame_done_reg  <= 1'b1;
            frame_pend_reg  <= 1'b0;
            pixel_ready_reg <= 1'b1;
          end else begin
            pixel_ready_reg <= !frame_pend_reg;
          end
        end
`ifdef UART_TX_FRAME_HEADER_EN
        DIS_HDR0:   if (!fifo_full) dis_state_reg <= DIS_HDR1;
        DIS_HDR1:   if (!fifo_full) dis_state_reg <= DIS_BYTE_R;
`endif
        DIS_BYTE_R: if (!fifo_full) dis_state_reg <= DIS_BYTE_G;
        DIS_BYTE_G: if (!fifo_full) dis_state_reg <= DIS_BYTE_B;
        DIS_BYTE_B: begin
          if (!fifo_full) begin
            dis_state_reg   <= DIS_IDLE;
            pixel_ready_reg <= !frame_pend_reg;
          end
        end
        default: dis_state_reg <= DIS_IDLE;
      endcase
    end
  end

  // Serializer: tx is registered, so each state's line level is set on entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ser_state_reg <= SER_IDLE;
      baud_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= 1'b1;
    end else begin
      case (ser_state_reg)
        SER_IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg     <= fifo_mem[rd_ptr_reg[FIFO_DEPTH-1:0]];
            baud_cnt_reg  <= '0;
            tx_reg        <= 1'b0;
            ser_state_reg <= SER_START;
          end
        end
        SER_START: begin
          if (baud_end) begin
            baud_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            tx_reg        <= shift_reg[0];
            ser_state_reg <= SER_DATA;
          end else begin
            baud_cnt_reg  <= baud_cnt_reg + 1'b1;
          end
        end
        SER_DATA: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1)) begin
              tx_reg        <= 1'b1;
              ser_state_reg <= SER_STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        SER_STOP: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            if (pop) begin
              shift_reg     <= fifo_mem[rd_ptr_reg[FIFO_DEPTH-1:0]];
              tx_reg        <= 1'b0;
              ser_state_reg <= SER_START;
            end else begin
              ser_state_reg <= SER_IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: ser_state_reg <= SER_IDLE;
      endcase
    end
  end

  assign pixel_ready = pixel_ready_reg;
  assign tx          = tx_reg;
  assign tx_busy     = !fifo_empty || (ser_state_reg != SER_IDLE);
  assign pixel_cnt   = pixel_cnt_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a UART receiver monitor checks every byte on the line.
// Instance a is the 2x2 frame configuration; instance b has a larger frame to fill its FIFO.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_a, valid_b;
  logic [23:0] rgb;
  logic        ready_a, tx_a, busy_a, done_a;
  logic        ready_b, tx_b, busy_b, done_b;
  logic [1:0]  cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .IMG_WIDTH(2), .IMG_HEIGHT(2)) dut_a (
    .clk(clk), .reset(reset), .pixel_valid(valid_a), .rgb_data(rgb), .pixel_ready(ready_a),
    .tx(tx_a), .tx_busy(busy_a), .pixel_cnt(cnt_a), .frame_done(done_a));

  uart_tx_frame #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_b (
    .clk(clk), .reset(reset), .pixel_valid(valid_b), .rgb_data(rgb), .pixel_ready(ready_b),
    .tx(tx_b), .tx_busy(busy_b), .pixel_cnt(cnt_b), .frame_done(done_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sel_b = 1'b0;
  logic mon_tx, cur_ready, cur_busy;
  assign mon_tx    = sel_b ? tx_b : tx_a;
  assign cur_ready = sel_b ? ready_b : ready_a;
  assign cur_busy  = sel_b ? busy_b : busy_a;

  logic [7:0] exp_q[$];
  bit first_in_burst = 1'b1;
  int prev_start = 0;
  int last_end = 0;
  int start_cnt = 0;
  int rx_cnt = 0;
  int done_cnt_a = 0;
  int done_cyc = 0;
  int model_cnt_a = 0;
  int model_cnt_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic mon_wait(input int n, output bit ab);
    ab = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!reset) begin ab = 1'b1; return; end
    end
  endtask

  // Receiver: start detected on its first cycle, bits sampled mid-period.
  initial begin : monitor
    logic [7:0] b;
    logic       stopb;
    logic [7:0] e;
    int         s;
    bit         ab;
    forever begin
      @(negedge clk);
      if (reset && mon_tx == 1'b0) begin
        s = cyc;
        start_cnt++;
        b = '0;
        stopb = 1'b0;
        mon_wait(8, ab);
        for (int i = 0; i < 8; i++) begin
          if (!ab) begin mon_wait(16, ab); b[i] = mon_tx; end
        end
        if (!ab) begin mon_wait(16, ab); stopb = mon_tx; end
        if (!ab) mon_wait(7, ab);
        if (!ab) begin
          rx_cnt++;
          last_end = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got %0h expected no byte (cycle %0d)", b, cyc);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", {24'd0, b}, {24'd0, e});
          end
          check("rx_stop_bit", {31'd0, stopb}, 32'd1);
          if (!first_in_burst) check("rx_no_gap", s, prev_start + 160);
          first_in_burst = 1'b0;
          prev_start = s;
          $display("rx byte %02h at cycle %0d", b, s);
        end
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (done_a) begin done_cnt_a++; done_cyc = cyc; end
    end
  end

  task automatic expect_pixel(input logic [23:0] px);
`ifdef UART_TX_FRAME_HEADER_EN
    if ((sel_b ? model_cnt_b : model_cnt_a) == 0) begin
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
    end
`endif
    exp_q.push_back(px[23:16]);
    exp_q.push_back(px[15:8]);
    exp_q.push_back(px[7:0]);
    if (sel_b) model_cnt_b = (model_cnt_b + 1) % 16;
    else       model_cnt_a = (model_cnt_a + 1) % 4;
  endtask

  // Called at a negedge; returns at the negedge just after the handshake edge.
  task automatic send_pixel(input logic [23:0] px, input bit keep);
    int n = 0;
    expect_pixel(px);
    rgb = px;
    if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
    while (!cur_ready && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) check("handshake_timeout", 32'd1, 32'd0);
    @(negedge clk);
    $display("sent pixel %06h at cycle %0d", px, cyc);
    if (!keep) begin valid_a = 1'b0; valid_b = 1'b0; end
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || cur_busy) && n < limit) begin @(negedge clk); n++; end
    check("drain_in_time", {31'd0, n < limit}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin : stim
    int  base, rdy_bad, n, t12, t13, rx_base;
    logic [23:0] frame_px [4];
    frame_px[0] = 24'h102030; frame_px[1] = 24'h405060;
    frame_px[2] = 24'h708090; frame_px[3] = 24'hA0B0C0;
    reset = 1'b0; valid_a = 1'b0; valid_b = 1'b0; rgb = '0;

    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, tx_a}, 32'd1);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_ready", {31'd0, ready_a}, 32'd0);
    check("rst_cnt", {30'd0, cnt_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_tx", {31'd0, tx_a}, 32'd1);
    check("idle_busy", {31'd0, busy_a}, 32'd0);
    check("idle_ready", {31'd0, ready_a}, 32'd1);
    check("idle_cnt", {30'd0, cnt_a}, 32'd0);

    // One full frame with pixel_valid held high.
    first_in_burst = 1'b1;
    base = done_cnt_a;
    rx_base = rx_cnt;
    for (int i = 0; i < 4; i++) send_pixel(frame_px[i], i < 3);
    n = 0; rdy_bad = 0;
    while (done_cnt_a == base && n < 4000) begin
      @(negedge clk); n++;
      if (ready_a && !done_a && done_cnt_a == base) rdy_bad++;
    end
    repeat (20) @(negedge clk);
    check("frame_done_count", done_cnt_a - base, 32'd1);
    check("frame_done_timing", done_cyc, last_end + 2);
    check("frame_ready_low", rdy_bad, 32'd0);
    check("frame_cnt_wrap", {30'd0, cnt_a}, 32'd0);
    check("frame_ready_after", {31'd0, ready_a}, 32'd1);
    check("frame_exp_empty", exp_q.size(), 32'd0);
`ifdef UART_TX_FRAME_HEADER_EN
    check("frame_byte_total", rx_cnt - rx_base, 32'd14);
`else
    check("frame_byte_total", rx_cnt - rx_base, 32'd12);
`endif

    // Single pixel.
    first_in_burst = 1'b1;
    base = done_cnt_a;
    send_pixel(24'h123456, 1'b0);
    wait_drain(3000);
    check("one_px_cnt", {30'd0, cnt_a}, 32'd1);
    check("one_px_no_done", done_cnt_a - base, 32'd0);

    // Reset during data bit 3 of the 0x34 byte.
    first_in_burst = 1'b1;
    base = start_cnt;
    send_pixel(24'h123456, 1'b0);
    n = 0;
    while (start_cnt < base + 2 && n < 3000) begin @(negedge clk); n++; end
    check("second_byte_started", {31'd0, n < 3000}, 32'd1);
    repeat (70) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_tx", {31'd0, tx_a}, 32'd1);
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    check("midrst_cnt", {30'd0, cnt_a}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_cnt_a = 0;
    model_cnt_b = 0;
    first_in_burst = 1'b1;
    send_pixel(24'hA1B2C3, 1'b0);
    wait_drain(3000);
    check("post_rst_cnt", {30'd0, cnt_a}, 32'd1);
    check("post_rst_tx_idle", {31'd0, tx_a}, 32'd1);

    // Sustained stream into instance b until its FIFO fills and BYTE_x stalls.
    sel_b = 1'b1;
    first_in_burst = 1'b1;
    t12 = 0; t13 = 0;
    for (int i = 0; i < 13; i++) begin
      send_pixel({8'(3*i+1), 8'(3*i+2), 8'(3*i+3)}, i < 12);
      if (i == 11) t12 = cyc;
      if (i == 12) t13 = cyc;
    end
    check("fifo_full_stall", {31'd0, (t13 - t12) > 300}, 32'd1);
    wait_drain(10000);
    check("stream_cnt", {28'd0, cnt_b}, 32'd13);
    check("stream_exp_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
